// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM issue front end: decode, register file, ALU handshake, writeback
module alu_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] lhs,
  output logic                  lhs_valid,
  output logic [DATA_WIDTH-1:0] rhs,
  output logic                  rhs_valid,
  output logic [2:0]            operation,
  output logic                  operation_valid,
  output logic [6:0]            metadata,
  output logic                  metadata_valid,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  result_valid,
  output logic                  retire_valid,
  output logic [4:0]            retire_rd,
  output logic [DATA_WIDTH-1:0] retire_data,
  output logic                  illegal,
  output logic                  timeout,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_TRAP} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  live_q;
  logic [31:0]           instr_q;
  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] lhs_q, rhs_q, result_q;
  logic [2:0]            op_q;
  logic [6:0]            meta_q;
  logic [4:0]            rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  trap_illegal_q;

  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic [4:0]            rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, dec_rhs;
  logic [6:0]            dec_meta;
  logic                  dec_legal, is_shift, accept, cnt_expired;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7   = instr_q[31:25];
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

  // For OP-IMM the rs2/funct7 fields are imm[4:0]/imm[11:5], so shifts reuse them directly.
  always_comb begin
    dec_legal = 1'b0;
    dec_rhs   = rs2_val;
    dec_meta  = 7'd0;
    case (opcode)
      7'h33: begin
        dec_meta  = funct7;
        dec_rhs   = is_shift ? {{(DATA_WIDTH-5){1'b0}}, rs2_val[4:0]} : rs2_val;
        dec_legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end
      7'h13: begin
        if (is_shift) begin
          dec_rhs   = {{(DATA_WIDTH-5){1'b0}}, rs2};
          dec_meta  = funct7;
          dec_legal = (funct7 == 7'h00) || ((funct7 == 7'h20) && (funct3 == 3'd5));
        end else begin
          dec_rhs   = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
          dec_legal = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign instr_ready = live_q && (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign cnt_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (result_valid)     state_d = S_WB;
        else if (cnt_expired) state_d = S_TRAP;
      end
      S_WB:     state_d = S_IDLE;
      S_TRAP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      live_q         <= 1'b0;
      instr_q        <= '0;
      lhs_q          <= '0;
      rhs_q          <= '0;
      result_q       <= '0;
      op_q           <= '0;
      meta_q         <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
      trap_illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      case (state_q)
        S_IDLE: if (accept) instr_q <= instr;
        S_DECODE: begin
          cnt_q <= '0;
          if (dec_legal) begin
            lhs_q  <= rs1_val;
            rhs_q  <= dec_rhs;
            op_q   <= funct3;
            meta_q <= dec_meta;
            rd_q   <= rd;
          end else begin
            trap_illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (result_valid) begin
            result_q <= result;
            cnt_q    <= '0;
          end else if (cnt_expired) begin
            trap_illegal_q <= 1'b0;
            cnt_q          <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB: if (rd_q != 5'd0) regs_q[rd_q] <= result_q;
        default: ;
      endcase
    end
  end

  assign lhs             = lhs_q;
  assign rhs             = rhs_q;
  assign operation       = op_q;
  assign metadata        = meta_q;
  assign lhs_valid       = (state_q == S_EXEC);
  assign rhs_valid       = (state_q == S_EXEC);
  assign operation_valid = (state_q == S_EXEC);
  assign metadata_valid  = (state_q == S_EXEC);
  assign retire_valid    = (state_q == S_WB);
  assign retire_rd       = (state_q == S_WB) ? rd_q : 5'd0;
  assign retire_data     = (state_q == S_WB) ? result_q : '0;
  assign illegal         = (state_q == S_TRAP) && trap_illegal_q;
  assign timeout         = (state_q == S_TRAP) && !trap_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed bench for alu_issue with an expected-event scoreboard
module tb_alu_issue;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] lhs, rhs, result, retire_data, dbg_data;
  logic        lhs_valid, rhs_valid, operation_valid, metadata_valid;
  logic [2:0]  operation;
  logic [6:0]  metadata;
  logic        result_valid, retire_valid, illegal, timeout;
  logic [4:0]  retire_rd, dbg_addr;
  logic        alu_en;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_issue #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .lhs(lhs), .lhs_valid(lhs_valid), .rhs(rhs), .rhs_valid(rhs_valid),
    .operation(operation), .operation_valid(operation_valid),
    .metadata(metadata), .metadata_valid(metadata_valid),
    .result(result), .result_valid(result_valid),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
    .illegal(illegal), .timeout(timeout),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU answering in the first EXEC cycle.
  always_comb begin
    result       = 32'd0;
    result_valid = alu_en && lhs_valid && rhs_valid && operation_valid && metadata_valid;
    case (operation)
      3'd0: result = metadata[5] ? lhs - rhs : lhs + rhs;
      3'd1: result = lhs << rhs[4:0];
      3'd2: result = {31'd0, $signed(lhs) < $signed(rhs)};
      3'd3: result = {31'd0, lhs < rhs};
      3'd4: result = lhs ^ rhs;
      3'd5: result = metadata[5] ? 32'($signed(lhs) >>> rhs[4:0]) : lhs >> rhs[4:0];
      3'd6: result = lhs | rhs;
      default: result = lhs & rhs;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] expv);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, expv);
  endtask

  // kind: 0 retire, 1 illegal, 2 timeout. Called at a negedge with the DUT idle.
  task automatic issue(input string tag, input logic [31:0] ins, input int kind,
                       input logic [4:0] rd, input logic [31:0] data, input int lat,
                       input bit chk_ex, input logic [31:0] e_rhs,
                       input logic [6:0] e_meta, input logic [2:0] e_op);
    exp_t e;
    int   cyc;
    bit   seen;
    int   obs_kind;
    e = '{kind, rd, data, lat};
    sb.push_back(e);
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (cyc == 2 && chk_ex) begin
        chk({tag, "_exec_valid"}, {31'd0, lhs_valid}, 32'd1);
        chk({tag, "_rhs"}, rhs, e_rhs);
        chk({tag, "_meta"}, {25'd0, metadata}, {25'd0, e_meta});
        chk({tag, "_op"}, {29'd0, operation}, {29'd0, e_op});
      end
      if (retire_valid || illegal || timeout) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_no_event observed=none expected=kind%0d", tag, e.kind);
    end else begin
      obs_kind = retire_valid ? 0 : (illegal ? 1 : 2);
      chk({tag, "_kind"}, obs_kind, e.kind);
      chk({tag, "_lat"}, cyc, e.lat);
      if (e.kind == 0) begin
        chk({tag, "_rd"}, {27'd0, retire_rd}, {27'd0, e.rd});
        chk({tag, "_data"}, retire_data, e.data);
      end
      @(negedge clk);
      chk({tag, "_pulse_end"}, {31'd0, retire_valid | illegal | timeout}, 32'd0);
      chk({tag, "_ready_after"}, {31'd0, instr_ready}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b0; instr = '0; instr_valid = 1'b0; dbg_addr = '0; alu_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_valids", {28'd0, lhs_valid, rhs_valid, operation_valid, metadata_valid}, 32'd0);
    chk("rst_pulses", {29'd0, retire_valid, illegal, timeout}, 32'd0);
    chk("rst_lhs", lhs, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, instr_ready}, 32'd1);

    issue("addi_x1", 32'h00500093, 0, 5'd1, 32'h5, 3, 1'b1, 32'h5, 7'h00, 3'd0);
    dbg("dbg_x1", 5'd1, 32'h5);
    issue("addi_x2", 32'hFFD00113, 0, 5'd2, 32'hFFFFFFFD, 3, 1'b0, 0, 0, 0);
    issue("sub_x3", 32'h402081B3, 0, 5'd3, 32'h8, 3, 1'b1, 32'hFFFFFFFD, 7'h20, 3'd0);
    dbg("dbg_x2", 5'd2, 32'hFFFFFFFD);
    dbg("dbg_x3", 5'd3, 32'h8);
    issue("srai_x4", 32'h40115213, 0, 5'd4, 32'hFFFFFFFE, 3, 1'b1, 32'd1, 7'h20, 3'd5);
    issue("sll_x5", 32'h002092B3, 0, 5'd5, 32'hA0000000, 3, 1'b1, 32'd29, 7'h00, 3'd1);
    dbg("dbg_x5", 5'd5, 32'hA0000000);
    issue("ill_zero", 32'h00000000, 1, 5'd0, 32'd0, 2, 1'b0, 0, 0, 0);
    issue("ill_f7", 32'h02208033, 1, 5'd0, 32'd0, 2, 1'b0, 0, 0, 0);
    issue("addi_x0", 32'h00700013, 0, 5'd0, 32'h7, 3, 1'b0, 0, 0, 0);
    dbg("dbg_x0", 5'd0, 32'h0);

    alu_en = 1'b0;
    issue("timeout_x7", 32'h00100393, 2, 5'd0, 32'd0, 2 + TO, 1'b0, 0, 0, 0);
    alu_en = 1'b1;
    dbg("dbg_x7", 5'd7, 32'h0);

    instr = 32'h00900313; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec", {31'd0, lhs_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valids", {28'd0, lhs_valid, rhs_valid, operation_valid, metadata_valid}, 32'd0);
    chk("mid_rst_rhs", rhs, 32'd0);
    chk("mid_rst_pulses", {29'd0, retire_valid, illegal, timeout}, 32'd0);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
    dbg("mid_rst_x1", 5'd1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_retire", {31'd0, retire_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    dbg("post_rst_x6", 5'd6, 32'h0);
    dbg("post_rst_x3", 5'd3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
